// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// State encoding, coin values and the 1-bit coin-type code held in the FIFO.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VEND,
    CHANGE
  } state_t;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;

  localparam logic COIN_T5  = 1'b0;
  localparam logic COIN_T10 = 1'b1;

endpackage

// File: rtl/vend_controller_fifo.sv
// coin_fifo: 1-bit coin-type queue, QDEPTH entries, up to two pushes per cycle.
// Ports: clk, reset, push_a/data_a, push_b/data_b (written after a), pop, head, count, empty.
module coin_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_a,
  input  logic                      data_a,
  input  logic                      push_b,
  input  logic                      data_b,
  input  logic                      pop,
  output logic                      head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      empty
);

  localparam int AW = $clog2(QDEPTH);

  logic [QDEPTH-1:0] mem;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     wptr_b;

  // b lands behind a when both push in the same cycle
  assign wptr_b = wptr + AW'(push_a);
  assign head   = mem[rptr];
  assign empty  = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_a) mem[wptr] <= data_a;
      if (push_b) mem[wptr_b] <= data_b;
      wptr  <= wptr + AW'(push_a) + AW'(push_b);
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push_a)
                     + (AW+1)'(push_b)
                     - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin queue, credit, motor handshake, change payout.
// Ports: coin_5/coin_10/cancel/motor_done in; coin_accept_en, coin_reject,
// motor_req, change_5, credit, busy, fault out.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6,
  parameter int QDEPTH   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                cancel,
  input  logic                motor_done,
  output logic                coin_accept_en,
  output logic                coin_reject,
  output logic                motor_req,
  output logic                change_5,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault
);

  localparam int AW = $clog2(QDEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(COIN5_VAL);
  localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(COIN10_VAL);

  state_t              state;
  state_t              state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic                fault_n;
  logic [TW-1:0]       timer;
  logic [AW:0]         count;
  logic                empty;
  logic                head;
  logic                pop;

  // two free slots guarantee a dual-coin cycle never overflows
  assign coin_accept_en = (count <= (AW+1)'(QDEPTH - 2));

  coin_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_a (coin_5 & coin_accept_en),
    .data_a (COIN_T5),
    .push_b (coin_10 & coin_accept_en),
    .data_b (COIN_T10),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .empty  (empty)
  );

  always_comb begin
    state_n  = state;
    credit_n = credit;
    fault_n  = fault;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (credit >= PRICE_C) begin
          state_n = VEND;
        end else if (cancel && credit != '0) begin
          state_n = CHANGE;
        end else if (!empty) begin
          pop      = 1'b1;
          credit_n = credit + ((head == COIN_T10) ? C10 : C5);
        end
      end
      VEND: begin
        // done wins over a coincident timeout
        if (motor_done) begin
          credit_n = credit - PRICE_C;
          state_n  = (credit_n != '0) ? CHANGE : IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          fault_n = 1'b1;
          state_n = CHANGE;
        end
      end
      CHANGE: begin
        credit_n = credit - C5;
        if (credit_n == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      fault       <= 1'b0;
      timer       <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      fault       <= fault_n;
      coin_reject <= (coin_5 | coin_10) & ~coin_accept_en;
      if (state == VEND && state_n == VEND) timer <= timer + 1'b1;
      else timer <= '0;
    end
  end

  assign motor_req = (state == VEND);
  assign change_5  = (state == CHANGE);
  assign busy      = (state != IDLE) || !empty;

endmodule
